// File: rtl/ifetch_unit.sv
// Instruction fetch stage: one outstanding imem read and a valid/ready hand-off to decode.
// Defining IFETCH_LAST_HIT_EN adds a one-entry last-fetch buffer that bypasses memory on a repeat pc.
module ifetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          XLEN       = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc,
    input  logic            pc_valid,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic            misalign,
    output logic            fetch_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic            imem_req_r, imem_req_s;
    logic [XLEN-1:0] imem_addr_r, imem_addr_s;
    logic [XLEN-1:0] instr_r, instr_s;
    logic [XLEN-1:0] instr_pc_r, instr_pc_s;
    logic            instr_valid_r, instr_valid_s;
    logic            misalign_r, misalign_s;
    logic            drop_r, drop_s;
    logic            tag_wr_s;
    logic            hit_s;
    logic [XLEN-1:0] tag_data_s;

`ifdef IFETCH_LAST_HIT_EN
    logic            tag_valid_r;
    logic [XLEN-1:0] tag_addr_r;
    logic [XLEN-1:0] tag_data_r;

    assign hit_s      = tag_valid_r && (pc == tag_addr_r);
    assign tag_data_s = tag_data_r;

    // Last-fetch buffer, refreshed by every response that reaches decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_r <= 1'b0;
            tag_addr_r  <= RESET_ADDR;
            tag_data_r  <= {XLEN{1'b0}};
        end else if (tag_wr_s) begin
            tag_valid_r <= 1'b1;
            tag_addr_r  <= imem_addr_r;
            tag_data_r  <= imem_rdata;
        end else begin
            tag_valid_r <= tag_valid_r;
            tag_addr_r  <= tag_addr_r;
            tag_data_r  <= tag_data_r;
        end
    end
`else
    assign hit_s      = 1'b0;
    assign tag_data_s = {XLEN{1'b0}};
`endif

    // Next-state and next-output decode; misalign is a one-cycle flag rebuilt every cycle.
    always_comb begin
        state_s       = state_r;
        imem_req_s    = imem_req_r;
        imem_addr_s   = imem_addr_r;
        instr_s       = instr_r;
        instr_pc_s    = instr_pc_r;
        instr_valid_s = instr_valid_r;
        misalign_s    = 1'b0;
        drop_s        = drop_r;
        tag_wr_s      = 1'b0;
        case (state_r)
            IDLE: begin
                drop_s = 1'b0;
                if (flush) begin
                    state_s = IDLE;
                end else if (pc_valid && (pc[1:0] != 2'b00)) begin
                    misalign_s = 1'b1;
                end else if (pc_valid && hit_s) begin
                    instr_s       = tag_data_s;
                    instr_pc_s    = pc;
                    instr_valid_s = 1'b1;
                    state_s       = HOLD;
                end else if (pc_valid) begin
                    imem_req_s  = 1'b1;
                    imem_addr_s = {pc[XLEN-1:2], 2'b00};
                    state_s     = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                // A request is never withdrawn; a flush only marks the response for discard.
                if (flush) begin
                    drop_s = 1'b1;
                end else begin
                    drop_s = drop_r;
                end
                if (imem_gnt) begin
                    imem_req_s = 1'b0;
                    state_s    = WAIT;
                end else begin
                    imem_req_s = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (drop_r || flush) begin
                        drop_s  = 1'b0;
                        state_s = IDLE;
                    end else begin
                        instr_s       = imem_rdata;
                        instr_pc_s    = imem_addr_r;
                        instr_valid_s = 1'b1;
                        tag_wr_s      = 1'b1;
                        state_s       = HOLD;
                    end
                end else if (flush) begin
                    drop_s = 1'b1;
                end else begin
                    drop_s = drop_r;
                end
            end
            HOLD: begin
                if (flush || instr_ready) begin
                    instr_valid_s = 1'b0;
                    state_s       = IDLE;
                end else begin
                    instr_valid_s = 1'b1;
                end
            end
            default: begin
                state_s       = IDLE;
                imem_req_s    = 1'b0;
                instr_valid_s = 1'b0;
                drop_s        = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            imem_req_r    <= 1'b0;
            imem_addr_r   <= RESET_ADDR;
            instr_r       <= {XLEN{1'b0}};
            instr_pc_r    <= RESET_ADDR;
            instr_valid_r <= 1'b0;
            misalign_r    <= 1'b0;
            drop_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            imem_req_r    <= imem_req_s;
            imem_addr_r   <= imem_addr_s;
            instr_r       <= instr_s;
            instr_pc_r    <= instr_pc_s;
            instr_valid_r <= instr_valid_s;
            misalign_r    <= misalign_s;
            drop_r        <= drop_s;
        end
    end

    assign imem_req    = imem_req_r;
    assign imem_addr   = imem_addr_r;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign instr_valid = instr_valid_r;
    assign misalign    = misalign_r;
    assign fetch_busy  = (state_r != IDLE);

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed, table-driven bench for ifetch_unit plus hand sequences for reset and the last-hit buffer.
module tb_ifetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        misalign;
    logic        fetch_busy;

    int n_cmp = 0;
    int n_err = 0;
    int hs_cnt = 0;

    ifetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .misalign    (misalign),
        .fetch_busy  (fetch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted memory requests.
    always @(posedge clk) begin
        if (rst_n && imem_req && imem_gnt) hs_cnt <= hs_cnt + 1;
    end

    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic        fl;
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic        e_mis;
        logic        e_busy;
    } vec_t;

    localparam int NV = 53;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic pv, input logic [31:0] pca, input logic fl,
                                input logic gnt, input logic rv, input logic [31:0] rd,
                                input logic rdy, input logic e_req, input logic [31:0] e_addr,
                                input logic e_iv, input logic [31:0] e_instr,
                                input logic [31:0] e_ipc, input logic e_mis, input logic e_busy);
        vec_t v;
        v.pv = pv; v.pc = pca; v.fl = fl; v.gnt = gnt; v.rv = rv; v.rd = rd; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_instr = e_instr;
        v.e_ipc = e_ipc; v.e_mis = e_mis; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s step%0d got=%h expected=%h", name, idx, got, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic e_req, input logic [31:0] e_addr, input logic e_iv,
                           input logic [31:0] e_instr, input logic [31:0] e_ipc, input logic e_mis,
                           input logic e_busy);
        chk("imem_req", idx, {31'd0, imem_req}, {31'd0, e_req});
        chk("imem_addr", idx, imem_addr, e_addr);
        chk("instr_valid", idx, {31'd0, instr_valid}, {31'd0, e_iv});
        chk("instr", idx, instr, e_instr);
        chk("instr_pc", idx, instr_pc, e_ipc);
        chk("misalign", idx, {31'd0, misalign}, {31'd0, e_mis});
        chk("fetch_busy", idx, {31'd0, fetch_busy}, {31'd0, e_busy});
    endtask

    task automatic drive(input logic pv, input logic [31:0] pca, input logic fl, input logic gnt,
                         input logic rv, input logic [31:0] rd, input logic rdy);
        pc_valid = pv; pc = pca; flush = fl; imem_gnt = gnt;
        imem_rvalid = rv; imem_rdata = rd; instr_ready = rdy;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // basic fetch
        vecs[0]  = mk(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        vecs[1]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        vecs[2]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h00500093, 1'b0, 1'b0, 32'h100, 1'b1, 32'h00500093, 32'h100, 1'b0, 1'b1);
        vecs[3]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 1'b0, 32'h00500093, 32'h100, 1'b0, 1'b0);
        // grant delayed three cycles
        vecs[4]  = mk(1'b1, 32'h204, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h204, 1'b0, 32'h00500093, 32'h100, 1'b0, 1'b1);
        vecs[5]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h204, 1'b0, 32'h00500093, 32'h100, 1'b0, 1'b1);
        vecs[6]  = vecs[5];
        vecs[7]  = vecs[5];
        vecs[8]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h204, 1'b0, 32'h00500093, 32'h100, 1'b0, 1'b1);
        vecs[9]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h204, 1'b0, 32'h00500093, 32'h100, 1'b0, 1'b1);
        vecs[10] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h13, 1'b0, 1'b0, 32'h204, 1'b1, 32'h13, 32'h204, 1'b0, 1'b1);
        vecs[11] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h204, 1'b0, 32'h13, 32'h204, 1'b0, 1'b0);
        // flush in WAIT before rvalid, then a normal fetch
        vecs[12] = mk(1'b1, 32'h208, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h208, 1'b0, 32'h13, 32'h204, 1'b0, 1'b1);
        vecs[13] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h208, 1'b0, 32'h13, 32'h204, 1'b0, 1'b1);
        vecs[14] = mk(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h208, 1'b0, 32'h13, 32'h204, 1'b0, 1'b1);
        vecs[15] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h208, 1'b0, 32'h13, 32'h204, 1'b0, 1'b0);
        vecs[16] = mk(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h13, 32'h204, 1'b0, 1'b1);
        vecs[17] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h300, 1'b0, 32'h13, 32'h204, 1'b0, 1'b1);
        vecs[18] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h00A00113, 1'b0, 1'b0, 32'h300, 1'b1, 32'h00A00113, 32'h300, 1'b0, 1'b1);
        // decode stall with a pending pc that must be ignored
        vecs[19] = mk(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h300, 1'b1, 32'h00A00113, 32'h300, 1'b0, 1'b1);
        vecs[20] = vecs[19];
        vecs[21] = vecs[19];
        vecs[22] = vecs[19];
        vecs[23] = vecs[19];
        vecs[24] = mk(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 1'b0, 32'h00A00113, 32'h300, 1'b0, 1'b0);
        vecs[25] = mk(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h500, 1'b0, 32'h00A00113, 32'h300, 1'b0, 1'b1);
        vecs[26] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h500, 1'b0, 32'h00A00113, 32'h300, 1'b0, 1'b1);
        vecs[27] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0, 1'b0, 32'h500, 1'b1, 32'h11111111, 32'h500, 1'b0, 1'b1);
        vecs[28] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 1'b0, 32'h11111111, 32'h500, 1'b0, 1'b0);
        // misalign set and cleared by aligned pc, by !pc_valid and by flush
        vecs[29] = mk(1'b1, 32'h102, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h500, 1'b0, 32'h11111111, 32'h500, 1'b1, 1'b0);
        vecs[30] = vecs[29];
        vecs[31] = mk(1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h400, 1'b0, 32'h11111111, 32'h500, 1'b0, 1'b1);
        vecs[32] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h400, 1'b0, 32'h11111111, 32'h500, 1'b0, 1'b1);
        vecs[33] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h22222222, 1'b0, 1'b0, 32'h400, 1'b1, 32'h22222222, 32'h400, 1'b0, 1'b1);
        vecs[34] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 1'b0, 32'h22222222, 32'h400, 1'b0, 1'b0);
        vecs[35] = mk(1'b1, 32'h103, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h400, 1'b0, 32'h22222222, 32'h400, 1'b1, 1'b0);
        vecs[36] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h400, 1'b0, 32'h22222222, 32'h400, 1'b0, 1'b0);
        vecs[37] = mk(1'b1, 32'h101, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h400, 1'b0, 32'h22222222, 32'h400, 1'b1, 1'b0);
        vecs[38] = mk(1'b1, 32'h600, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h400, 1'b0, 32'h22222222, 32'h400, 1'b0, 1'b0);
        // flush together with gnt in REQ
        vecs[39] = mk(1'b1, 32'h600, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h600, 1'b0, 32'h22222222, 32'h400, 1'b0, 1'b1);
        vecs[40] = mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h600, 1'b0, 32'h22222222, 32'h400, 1'b0, 1'b1);
        vecs[41] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h33333333, 1'b0, 1'b0, 32'h600, 1'b0, 32'h22222222, 32'h400, 1'b0, 1'b0);
        // flush coincident with rvalid
        vecs[42] = mk(1'b1, 32'h700, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h700, 1'b0, 32'h22222222, 32'h400, 1'b0, 1'b1);
        vecs[43] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h700, 1'b0, 32'h22222222, 32'h400, 1'b0, 1'b1);
        vecs[44] = mk(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h44444444, 1'b0, 1'b0, 32'h700, 1'b0, 32'h22222222, 32'h400, 1'b0, 1'b0);
        // flush beats instr_ready in HOLD
        vecs[45] = mk(1'b1, 32'h800, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h800, 1'b0, 32'h22222222, 32'h400, 1'b0, 1'b1);
        vecs[46] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h800, 1'b0, 32'h22222222, 32'h400, 1'b0, 1'b1);
        vecs[47] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h55555555, 1'b0, 1'b0, 32'h800, 1'b1, 32'h55555555, 32'h800, 1'b0, 1'b1);
        vecs[48] = mk(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h800, 1'b0, 32'h55555555, 32'h800, 1'b0, 1'b0);
        // flush in REQ without gnt: request held, response dropped
        vecs[49] = mk(1'b1, 32'h900, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h900, 1'b0, 32'h55555555, 32'h800, 1'b0, 1'b1);
        vecs[50] = mk(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h900, 1'b0, 32'h55555555, 32'h800, 1'b0, 1'b1);
        vecs[51] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h900, 1'b0, 32'h55555555, 32'h800, 1'b0, 1'b1);
        vecs[52] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h66666666, 1'b0, 1'b0, 32'h900, 1'b0, 32'h55555555, 32'h800, 1'b0, 1'b0);

        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        #23;
        chk_all(1000, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        chk_all(1001, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].pv, vecs[i].pc, vecs[i].fl, vecs[i].gnt, vecs[i].rv, vecs[i].rd, vecs[i].rdy);
            step();
            chk_all(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_iv, vecs[i].e_instr,
                    vecs[i].e_ipc, vecs[i].e_mis, vecs[i].e_busy);
        end
        chk("handshakes", 2000, hs_cnt, 32'd10);

        // async reset while in WAIT, late rvalid after release must be ignored
        drive(1'b1, 32'hA00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
        chk_all(2001, 1'b0, 32'hA00, 1'b0, 32'h55555555, 32'h800, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_all(2002, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h77777777, 1'b0);
        step();
        chk_all(2003, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        chk_all(2004, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();

`ifdef IFETCH_LAST_HIT_EN
        // second fetch of the same pc is served from the buffer in one cycle
        drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h00500093, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step();
        chk_all(3000, 1'b0, 32'h100, 1'b0, 32'h00500093, 32'h100, 1'b0, 1'b0);
        drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        chk_all(3001, 1'b0, 32'h100, 1'b1, 32'h00500093, 32'h100, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step();
        chk_all(3002, 1'b0, 32'h100, 1'b0, 32'h00500093, 32'h100, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage directly downstream of the program-counter stage in the RV32I core.
- Takes the current PC and issues one word read to instruction memory over a req/gnt/rvalid handshake.
- Captures the returned instruction and presents it to decode with a valid/ready handshake.
- Redirect flushes (jal, taken branch, jalr) discard any in-flight fetch; at most one transaction is outstanding.

Parameters:
- RESET_ADDR, 32'h0000_0000, value of imem_addr and instr_pc after reset
- XLEN, 32, address/data width; only 32 is supported

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- pc  input  32  fetch address from PC stage
- pc_valid  input  1  pc is stable and a fetch is requested
- flush  input  1  redirect taken; abandon current fetch
- imem_req  output  1  memory read request
- imem_addr  output  32  memory read address, word aligned
- imem_gnt  input  1  memory accepted the request this cycle
- imem_rvalid  input  1  imem_rdata valid this cycle
- imem_rdata  input  32  read data
- instr  output  32  fetched instruction
- instr_pc  output  32  address instr was fetched from
- instr_valid  output  1  instr/instr_pc valid for decode
- instr_ready  input  1  decode accepts instr this cycle
- misalign  output  1  pc_valid seen with pc[1:0] != 0
- fetch_busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, imem_req=0, imem_addr=RESET_ADDR, instr=0, instr_pc=RESET_ADDR, instr_valid=0, misalign=0, drop=0.
  - Reset releasing mid-transaction: any imem_rvalid arriving while in IDLE or REQ is ignored.
- Outputs: all are registered except fetch_busy, which is decoded from state.
- FSM, IDLE:
  - flush has priority and the FSM stays in IDLE.
  - pc_valid with pc[1:0] != 0: misalign=1 next cycle, no request, stay in IDLE. misalign clears on the first cycle with !pc_valid, an aligned pc, or flush.
  - pc_valid with aligned pc: latch imem_addr=pc, set imem_req=1, go to REQ.
- FSM, REQ:
  - imem_req held at 1 and imem_addr held stable until imem_gnt=1; a request is never withdrawn.
  - On imem_gnt: imem_req=0, go to WAIT.
  - flush in REQ, with or without gnt: set drop=1; the handshake still completes.
- FSM, WAIT:
  - On imem_rvalid with drop=1: discard data, drop=0, go to IDLE.
  - On imem_rvalid with drop=0: instr=imem_rdata, instr_pc=imem_addr, instr_valid=1, go to HOLD.
  - flush in WAIT without same-cycle rvalid: drop=1.
  - flush coincident with rvalid: data is discarded.
- FSM, HOLD:
  - instr, instr_pc and instr_valid are held stable while !instr_ready.
  - instr_ready=1: instr_valid=0, go to IDLE.
  - flush: instr_valid=0, go to IDLE. flush wins over instr_ready.
- Latency:
  - Cycle 0: pc_valid sampled. Cycle 1: imem_req high. Gnt in cycle 1 gives WAIT in cycle 2. rvalid in cycle 2 gives instr_valid in cycle 3.
  - Minimum 3 cycles from pc_valid to instr_valid. Back-to-back throughput is one instruction per 4 cycles minimum.
- Widths: imem_addr[1:0] is always 0. No arithmetic is performed on pc; pc+4 is owned by the PC stage.

Optional Feature:
- Macro: IFETCH_LAST_HIT_EN.
- Defined:
  - A one-entry buffer holds {tag_valid, tag_addr, tag_data}.
  - It is written on every non-dropped response in WAIT; tag_valid is cleared on reset.
  - In IDLE, an aligned pc_valid with tag_valid && pc==tag_addr && !flush loads instr=tag_data, instr_pc=pc, instr_valid=1 and goes straight to HOLD with no imem_req. Latency is 1 cycle.
- Undefined: every fetch goes to memory; no buffer storage is synthesized.

Test Plan:
- Reset, then pc=0x100, pc_valid=1, gnt in cycle 1, rvalid in cycle 2 with rdata 0x00500093 -> instr_valid=1 in cycle 3, instr=0x00500093, instr_pc=0x100.
- Gnt delayed 3 cycles with pc=0x204 -> imem_req stays high and imem_addr=0x204 is stable for all 3 cycles; exactly one request is accepted.
- flush in WAIT before rvalid (rdata 0xDEADBEEF) -> data discarded, instr_valid never rises, FSM returns to IDLE; next pc=0x300 fetch completes normally.
- Decode stalls: instr_ready=0 for 5 cycles -> instr and instr_valid stable; instr_ready=1 -> instr_valid=0 next cycle and no new request that cycle.
- pc=0x102, pc_valid=1 -> misalign=1 next cycle, imem_req stays 0; an aligned pc clears misalign.
- rst_n pulled low in WAIT, with rvalid arriving after release -> all outputs return to reset values asynchronously; the late rvalid is ignored and instr_valid stays 0.
- IFETCH_LAST_HIT_EN defined: fetch 0x100, then fetch 0x100 again -> second fetch gives instr_valid 1 cycle after pc_valid with imem_req=0.
